alu_mc: RTL and testbench



---
 rtl/alu_mc.sv | 204 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle signed ALU for the MUSA datapath.
// Add/sub/logic/BRFL finish in one cycle; multiply and divide
// run one bit per cycle behind a start/busy/done handshake.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           request, sampled only while idle
//   func            operation code
//   op1, op2        signed operands
//   flags_in        {above, equals, overflow} compared by BRFL
//   busy            multi-cycle operation in flight
//   done            one-cycle pulse, result/flags updated
//   result          registered result
//   flags_out       registered {above, equals, overflow}
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags_out
);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MUL  = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOT  = 6'b100111;
    localparam logic [5:0] F_BRFL = 6'b111111;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] acc;
    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   dsr;
    logic               sign;
    logic               is_div;

    logic             is_mul_f;
    logic             is_div_f;
    logic             op2_zero;
    logic             go_iter;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign is_mul_f = (func == F_MUL);
    assign is_div_f = (func == F_DIV);
    assign op2_zero = (op2 == '0);
    assign go_iter  = start && (is_mul_f || (is_div_f && !op2_zero));

    // most-negative operand maps to 2^(WIDTH-1), still fits unsigned
    assign a_abs = op1[WIDTH-1] ? -op1 : op1;
    assign b_abs = op2[WIDTH-1] ? -op2 : op2;

    assign sum     = op1 + op2;
    assign diff    = op1 - op2;
    assign add_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                     (sum[WIDTH-1] != op1[WIDTH-1]);
    assign sub_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                     (diff[WIDTH-1] != op1[WIDTH-1]);

    // iteration step datapath
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                       {1'b0, {WIDTH{acc[0]}} & dsr};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, dsr};

    // sign fix-up datapath
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH:0]     prod_top;
    logic               mul_ovf;
    logic               div_ovf;

    assign prod     = sign ? -acc : acc;
    assign quot     = sign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // representable iff top WIDTH+1 bits are a pure sign extension
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = !((&prod_top) || !(|prod_top));
    // only min / -1 yields a positive quotient of 2^(WIDTH-1)
    assign div_ovf  = !sign && acc[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (go_iter) state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            dsr       <= '0;
            sign      <= 1'b0;
            is_div    <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags_out <= 3'b000;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go_iter) begin
                        acc    <= {{WIDTH{1'b0}}, is_mul_f ? b_abs : a_abs};
                        dsr    <= is_mul_f ? a_abs : b_abs;
                        sign   <= op1[WIDTH-1] ^ op2[WIDTH-1];
                        is_div <= is_div_f;
                        cnt    <= CNT_W'(WIDTH);
                    end else if (start) begin
                        done <= 1'b1;
                        unique case (func)
                            F_ADD: begin
                                result    <= sum;
                                flags_out <= {2'b00, add_ovf};
                            end
                            F_SUB: begin
                                result    <= diff;
                                flags_out <= {$signed(op1) > $signed(op2),
                                              op1 == op2, sub_ovf};
                            end
                            F_DIV: begin
                                result    <= '0;
                                flags_out <= 3'b001;
                            end
                            F_AND:  result <= op1 & op2;
                            F_OR:   result <= op1 | op2;
                            F_NOT:  result <= ~op1;
                            F_BRFL: begin
                                result <= {{(WIDTH-1){1'b0}},
                                           op1[2:0] == flags_in};
                            end
                            default: ;
                        endcase
                    end
                end
                ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        // restoring step: keep trial only if non-negative
                        acc <= div_trial[WIDTH] ?
                               {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                               {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    result    <= is_div ? quot : prod[WIDTH-1:0];
                    flags_out <= {2'b00, is_div ? div_ovf : mul_ovf};
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc at WIDTH 32 and 8.
// Hand vectors, handshake corner sequences and random ops vs a model.
module tb_alu_mc;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MUL  = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOT  = 6'b100111;
    localparam logic [5:0] F_BRFL = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s32, s8;
    logic [5:0]  f32, f8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [2:0]  fi32, fi8;
    logic        busy32, done32, busy8, done8;
    logic [31:0] r32;
    logic [7:0]  r8;
    logic [2:0]  fo32, fo8;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(s32), .func(f32),
        .op1(a32), .op2(b32), .flags_in(fi32), .busy(busy32),
        .done(done32), .result(r32), .flags_out(fo32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .func(f8),
        .op1(a8), .op2(b8), .flags_in(fi8), .busy(busy8),
        .done(done8), .result(r8), .flags_out(fo8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;
    int e0;

    // model state, index 0 = WIDTH 32, 1 = WIDTH 8
    longint     m_res[2];
    logic [2:0] m_flg[2];
    int         m_k;

    typedef struct {
        bit         w8;
        logic [5:0] f;
        longint     a;
        longint     b;
        logic [2:0] fin;
        longint     er;
        logic [2:0] ef;
        int         ek;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input longint got,
                         input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic longint dres(input bit w8);
        return w8 ? longint'(r8) : longint'(r32);
    endfunction

    function automatic logic [2:0] dflg(input bit w8);
        return w8 ? fo8 : fo32;
    endfunction

    task automatic model_reset();
        m_res[0] = 0; m_res[1] = 0;
        m_flg[0] = 3'b000; m_flg[1] = 3'b000;
    endtask

    // Plain-arithmetic reference: exact signed values, range checks.
    // m_k = number of the edge after E0 that makes done visible.
    task automatic model(input bit w8, input logic [5:0] f,
                         input longint a, input longint b,
                         input logic [2:0] fin);
        int w, ix;
        longint one, mask, mn, mx, sa, sb, v;
        w = w8 ? 8 : 32;
        ix = w8 ? 1 : 0;
        one = 1;
        mask = (one << w) - 1;
        mn = -(one << (w - 1));
        mx = (one << (w - 1)) - 1;
        sa = a & mask;
        if (sa > mx) sa -= one << w;
        sb = b & mask;
        if (sb > mx) sb -= one << w;
        m_k = 0;
        case (f)
            F_ADD: begin
                v = sa + sb;
                m_res[ix] = v & mask;
                m_flg[ix] = {2'b00, (v > mx) || (v < mn)};
            end
            F_SUB: begin
                v = sa - sb;
                m_res[ix] = v & mask;
                m_flg[ix] = {sa > sb, sa == sb, (v > mx) || (v < mn)};
            end
            F_MUL: begin
                v = sa * sb;
                m_res[ix] = v & mask;
                m_flg[ix] = {2'b00, (v > mx) || (v < mn)};
                m_k = w + 1;
            end
            F_DIV: begin
                if (sb == 0) begin
                    m_res[ix] = 0;
                    m_flg[ix] = 3'b001;
                end else begin
                    v = sa / sb;
                    m_res[ix] = v & mask;
                    m_flg[ix] = {2'b00, v > mx};
                    m_k = w + 1;
                end
            end
            F_AND:  m_res[ix] = sa & sb & mask;
            F_OR:   m_res[ix] = (sa | sb) & mask;
            F_NOT:  m_res[ix] = (~sa) & mask;
            F_BRFL: m_res[ix] = ((sa & 7) == longint'(fin)) ? 1 : 0;
            default: ;
        endcase
    endtask

    // called at a negedge; returns just after E0 with start low again
    task automatic issue(input bit w8, input logic [5:0] f,
                         input longint a, input longint b,
                         input logic [2:0] fin);
        model(w8, f, a, b, fin);
        if (w8) begin
            s8 = 1'b1; f8 = f; a8 = a[7:0]; b8 = b[7:0]; fi8 = fin;
        end else begin
            s32 = 1'b1; f32 = f; a32 = a[31:0]; b32 = b[31:0]; fi32 = fin;
        end
        @(posedge clk);
        #1;
        e0 = cyc;
        s8 = 1'b0;
        s32 = 1'b0;
        // scramble operands: in-flight op must not see them
        a8 = 8'($urandom); b8 = 8'($urandom);
        a32 = $urandom; b32 = $urandom;
        f8 = 6'($urandom); f32 = 6'($urandom);
        fi8 = 3'($urandom); fi32 = 3'($urandom);
    endtask

    task automatic wait_done(input bit w8, output int k);
        k = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((w8 ? done8 : done32) === 1'b1) begin
                k = cyc - e0;
                break;
            end
        end
        if (k < 0) begin
            n_run++;
            n_fail++;
            $display("FAIL done_timeout: got none want done w8=%0d", w8);
        end else begin
            check("busy_at_done", w8 ? busy8 : busy32, 0);
        end
    endtask

    task automatic run(input bit w8, input logic [5:0] f,
                       input longint a, input longint b,
                       input logic [2:0] fin, output longint r,
                       output logic [2:0] fl, output int k);
        @(negedge clk);
        issue(w8, f, a, b, fin);
        wait_done(w8, k);
        r = dres(w8);
        fl = dflg(w8);
    endtask

    function automatic longint pick(input bit w8);
        case ($urandom_range(0, 6))
            0: return 0;
            1: return 1;
            2: return -1;
            3: return w8 ? 'h80 : 'h8000_0000;
            4: return w8 ? 'h7f : 'h7fff_ffff;
            5: return longint'($urandom_range(1, 9));
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        logic [5:0] fl_tab[9];
        longint r;
        logic [2:0] fl;
        int k;
        bit w8;
        logic [5:0] f;

        fl_tab = '{F_ADD, F_SUB, F_MUL, F_DIV, F_AND,
                   F_OR, F_NOT, F_BRFL, 6'b000001};

        tbl.push_back('{0, F_ADD, 3, 4, 0, 7, 3'b000, 0});
        tbl.push_back('{0, F_SUB, 5, 3, 0, 2, 3'b100, 0});
        tbl.push_back('{0, F_SUB, 7, 7, 0, 0, 3'b010, 0});
        tbl.push_back('{0, F_ADD, 'h7fff_ffff, 1, 0,
                        'h8000_0000, 3'b001, 0});
        tbl.push_back('{0, F_AND, 'hf0f0, 'hff00, 0, 'hf000, 3'b001, 0});
        tbl.push_back('{0, F_OR, 'hf0, 'h0f, 0, 'hff, 3'b001, 0});
        tbl.push_back('{0, F_NOT, 0, 5, 0, 'hffff_ffff, 3'b001, 0});
        tbl.push_back('{0, F_BRFL, 'h15, 0, 3'b101, 1, 3'b001, 0});
        tbl.push_back('{0, F_BRFL, 'h15, 0, 3'b100, 0, 3'b001, 0});
        tbl.push_back('{0, F_MUL, -6, 7, 0, 'hffff_ffd6, 3'b000, 33});
        tbl.push_back('{0, F_MUL, 'h10000, 'h10000, 0, 0, 3'b001, 33});
        tbl.push_back('{0, F_DIV, -7, 2, 0, 'hffff_fffd, 3'b000, 33});
        tbl.push_back('{0, F_DIV, 5, 0, 0, 0, 3'b001, 0});
        tbl.push_back('{0, F_DIV, 'h8000_0000, -1, 0,
                        'h8000_0000, 3'b001, 33});
        tbl.push_back('{0, 6'b000000, 9, 9, 0, 'h8000_0000, 3'b001, 0});
        tbl.push_back('{0, F_SUB, -1, 1, 0, 'hffff_fffe, 3'b000, 0});
        tbl.push_back('{0, F_SUB, 'h8000_0000, 1, 0,
                        'h7fff_ffff, 3'b001, 0});
        tbl.push_back('{1, F_MUL, -6, 7, 0, 'hd6, 3'b000, 9});
        tbl.push_back('{1, F_MUL, 16, 8, 0, 'h80, 3'b001, 9});
        tbl.push_back('{1, F_DIV, 'h80, -1, 0, 'h80, 3'b001, 9});
        tbl.push_back('{1, F_DIV, 100, -7, 0, 'hf2, 3'b000, 9});
        tbl.push_back('{1, F_ADD, 'h7f, 1, 0, 'h80, 3'b001, 0});
        tbl.push_back('{1, F_BRFL, 3, 0, 3'b011, 1, 3'b001, 0});

        rst_n = 1'b0;
        s32 = 0; s8 = 0; f32 = 0; f8 = 0;
        a32 = 0; b32 = 0; a8 = 0; b8 = 0; fi32 = 0; fi8 = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy32", busy32, 0);
        check("rst_done32", done32, 0);
        check("rst_res32", r32, 0);
        check("rst_flg32", fo32, 0);
        check("rst_res8", r8, 0);
        check("rst_flg8", fo8, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].w8, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].fin,
                r, fl, k);
            check($sformatf("vec%0d_res", i), r, tbl[i].er);
            check($sformatf("vec%0d_flg", i), fl, tbl[i].ef);
            check($sformatf("vec%0d_edge", i), k, tbl[i].ek);
        end

        // reset in the middle of a multiply
        @(negedge clk);
        issue(0, F_MUL, 100, 200, 0);
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid_busy", busy32, 0);
        check("rstmid_done", done32, 0);
        check("rstmid_res", r32, 0);
        check("rstmid_flg", fo32, 0);
        repeat (2) @(negedge clk);
        check("rstmid_nodone", done32, 0);
        rst_n = 1'b1;
        run(0, F_ADD, 3, 4, 0, r, fl, k);
        check("rstmid_add_res", r, 7);
        check("rstmid_add_edge", k, 0);

        // start pulsed while busy is ignored
        @(negedge clk);
        issue(0, F_MUL, 100, 3, 0);
        repeat (3) @(negedge clk);
        s32 = 1'b1; f32 = F_ADD; a32 = 1; b32 = 1;
        @(negedge clk);
        s32 = 1'b0;
        wait_done(0, k);
        check("busystart_res", r32, 300);
        check("busystart_flg", fo32, 0);
        check("busystart_edge", k, 33);

        // start during the done cycle is accepted
        run(0, F_MUL, 3, 3, 0, r, fl, k);
        check("b2b_mul_res", r, 9);
        issue(0, F_ADD, 1, 2, 0);
        wait_done(0, k);
        check("b2b_add_res", r32, 3);
        check("b2b_add_edge", k, 0);
        @(negedge clk);
        check("done_width", done32, 0);

        for (int i = 0; i < 240; i++) begin
            w8 = (i % 2) == 1;
            f = fl_tab[$urandom_range(0, 8)];
            run(w8, f, pick(w8), pick(w8), 3'($urandom), r, fl, k);
            check($sformatf("rnd%0d_res f=%b", i, f), r, m_res[w8 ? 1 : 0]);
            check($sformatf("rnd%0d_flg f=%b", i, f), fl, m_flg[w8 ? 1 : 0]);
            check($sformatf("rnd%0d_edge f=%b", i, f), k, m_k);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
